// File: rtl/cache_arb_pkg.sv
// -----------------------------------------------------------------------------
// cache_arb_pkg
//   Shared types and default sizes for the cache-to-memory burst arbiter.
//   arb_state_t : arbiter FSM states (IDLE / XFER / DONE)
//   grant_t     : which cache owns the memory port (GNT_I / GNT_D)
//   DEF_*       : default ADDR_W / DATA_W / BEATS for cache_mem_arb
// -----------------------------------------------------------------------------
package cache_arb_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_BEATS  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/cache_mem_arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
//   Combinational grant selection between the I-cache and D-cache.
//   Build option: macro ARB_RR_EN selects round-robin on a tie (the requester
//   not granted most recently wins); without it D-cache has fixed priority and
//   last_gnt is ignored.
// Ports:
//   ic_req   in  I-cache request
//   dc_req   in  D-cache request
//   last_gnt in  most recent grant (only meaningful with ARB_RR_EN)
//   gnt      out selected requester; only meaningful when a request is high
// -----------------------------------------------------------------------------
module arb_pick
    import cache_arb_pkg::*;
(
    input  logic   ic_req,
    input  logic   dc_req,
    input  grant_t last_gnt,
    output grant_t gnt
);

`ifdef ARB_RR_EN
    always_comb begin
        gnt = GNT_I;
        if (ic_req && dc_req) begin
            // Tie: hand the port to whoever did not have it last.
            gnt = (last_gnt == GNT_I) ? GNT_D : GNT_I;
        end else if (dc_req) begin
            gnt = GNT_D;
        end else begin
            gnt = GNT_I;
        end
    end
`else
    // Fixed priority: any D request wins, so neither ic_req nor history matter.
    logic unused_pick;
    assign unused_pick = ic_req ^ (last_gnt == GNT_D);

    always_comb begin
        gnt = GNT_I;
        if (dc_req) begin
            gnt = GNT_D;
        end
    end
`endif

endmodule

// File: rtl/cache_mem_arb.sv
// -----------------------------------------------------------------------------
// cache_mem_arb
//   Arbitrates I-cache line reads and D-cache line reads / write-backs onto a
//   single main-memory port. Each grant moves one line as BEATS word beats,
//   one beat per mem_ack.
//   Build option: macro ARB_RR_EN enables round-robin tie-breaking (see
//   arb_pick); default is fixed D-over-I priority with no last-grant register.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   ic_req/ic_addr         I-cache line-read request and line address
//   ic_rdata/ic_rvalid     registered read beats to I-cache
//   ic_done                one-cycle completion pulse to I-cache
//   dc_req/dc_we/dc_addr   D-cache request, direction, line address
//   dc_wdata/dc_wnext      write beat from D-cache and its consume strobe
//   dc_rdata/dc_rvalid     registered read beats to D-cache
//   dc_done                one-cycle completion pulse to D-cache
//   mem_req/mem_we/mem_addr/mem_wdata   beat request to memory
//   mem_ack/mem_rdata      beat acknowledge and read data from memory
// -----------------------------------------------------------------------------
module cache_mem_arb
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BEATS  = DEF_BEATS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_rvalid,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_wnext,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_rvalid,
    output logic              dc_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LOG_B  = $clog2(BEATS);
    localparam int BASE_W = ADDR_W - LOG_B;
    localparam logic [LOG_B-1:0] LAST_BEAT = LOG_B'(BEATS - 1);

    arb_state_t        state_q, state_d;
    logic [LOG_B-1:0]  beat_q, beat_d;
    grant_t            gnt_q, gnt_d;
    logic [BASE_W-1:0] base_q, base_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] ic_rdata_q, ic_rdata_d;
    logic              ic_rvalid_q, ic_rvalid_d;
    logic [DATA_W-1:0] dc_rdata_q, dc_rdata_d;
    logic              dc_rvalid_q, dc_rvalid_d;

    grant_t            pick_gnt;
    grant_t            last_gnt;

    // Beat offset bits of the request addresses are replaced by the counter.
    logic unused_addr_low;
    assign unused_addr_low = ^{ic_addr[LOG_B-1:0], dc_addr[LOG_B-1:0]};

`ifdef ARB_RR_EN
    grant_t last_gnt_q, last_gnt_d;

    // Resets to I so that the first tie after reset goes to D.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= GNT_I;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (state_q == IDLE && (ic_req || dc_req)) begin
            last_gnt_d = pick_gnt;
        end
    end

    assign last_gnt = last_gnt_q;
`else
    assign last_gnt = GNT_I;
`endif

    arb_pick u_pick (
        .ic_req   (ic_req),
        .dc_req   (dc_req),
        .last_gnt (last_gnt),
        .gnt      (pick_gnt)
    );

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            gnt_q       <= GNT_I;
            base_q      <= '0;
            we_q        <= 1'b0;
            ic_rdata_q  <= '0;
            ic_rvalid_q <= 1'b0;
            dc_rdata_q  <= '0;
            dc_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            gnt_q       <= gnt_d;
            base_q      <= base_d;
            we_q        <= we_d;
            ic_rdata_q  <= ic_rdata_d;
            ic_rvalid_q <= ic_rvalid_d;
            dc_rdata_q  <= dc_rdata_d;
            dc_rvalid_q <= dc_rvalid_d;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        gnt_d       = gnt_q;
        base_d      = base_q;
        we_d        = we_q;
        ic_rdata_d  = ic_rdata_q;
        ic_rvalid_d = 1'b0;
        dc_rdata_d  = dc_rdata_q;
        dc_rvalid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ic_req || dc_req) begin
                    gnt_d   = pick_gnt;
                    beat_d  = '0;
                    state_d = XFER;
                    if (pick_gnt == GNT_D) begin
                        base_d = dc_addr[ADDR_W-1:LOG_B];
                        we_d   = dc_we;
                    end else begin
                        base_d = ic_addr[ADDR_W-1:LOG_B];
                        we_d   = 1'b0;
                    end
                end
            end
            XFER: begin
                if (mem_ack) begin
                    beat_d = beat_q + 1'b1;
                    // Read beats are forwarded only to the owner, and only
                    // for line reads; a write-back ack carries no data.
                    if (!we_q) begin
                        if (gnt_q == GNT_D) begin
                            dc_rdata_d  = mem_rdata;
                            dc_rvalid_d = 1'b1;
                        end else begin
                            ic_rdata_d  = mem_rdata;
                            ic_rvalid_d = 1'b1;
                        end
                    end
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        dc_wnext  = 1'b0;
        ic_done   = 1'b0;
        dc_done   = 1'b0;

        if (state_q == XFER) begin
            mem_req  = 1'b1;
            mem_we   = we_q;
            mem_addr = {base_q, beat_q};
            dc_wnext = mem_ack && we_q && (gnt_q == GNT_D);
        end
        if (state_q == DONE) begin
            ic_done = (gnt_q == GNT_I);
            dc_done = (gnt_q == GNT_D);
        end

        mem_wdata = dc_wdata;
        ic_rdata  = ic_rdata_q;
        ic_rvalid = ic_rvalid_q;
        dc_rdata  = dc_rdata_q;
        dc_rvalid = dc_rvalid_q;
    end

endmodule

// File: tb/tb_cache_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_arb
//   Directed self-checking bench for cache_mem_arb (default 16/16/4 build).
//   Honours ARB_RR_EN for the simultaneous-request scenario.
// -----------------------------------------------------------------------------
module tb_cache_mem_arb;

    logic        clk;
    logic        rst;
    logic        ic_req;
    logic [15:0] ic_addr;
    logic [15:0] ic_rdata;
    logic        ic_rvalid;
    logic        ic_done;
    logic        dc_req;
    logic        dc_we;
    logic [15:0] dc_addr;
    logic [15:0] dc_wdata;
    logic        dc_wnext;
    logic [15:0] dc_rdata;
    logic        dc_rvalid;
    logic        dc_done;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    cache_mem_arb dut (
        .clk       (clk),
        .rst       (rst),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_rdata  (ic_rdata),
        .ic_rvalid (ic_rvalid),
        .ic_done   (ic_done),
        .dc_req    (dc_req),
        .dc_we     (dc_we),
        .dc_addr   (dc_addr),
        .dc_wdata  (dc_wdata),
        .dc_wnext  (dc_wnext),
        .dc_rdata  (dc_rdata),
        .dc_rvalid (dc_rvalid),
        .dc_done   (dc_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // Acks every beat until a done pulse appears (bounded), then returns to IDLE
    // with both requests dropped.
    task automatic finish_xfer(output logic saw_i, output logic saw_d);
        saw_i = 1'b0;
        saw_d = 1'b0;
        mem_ack = 1'b1;
        for (int n = 0; n < 20; n++) begin
            mem_rdata = 16'h0C00 + 16'(n);
            cyc();
            if (ic_done || dc_done) begin
                saw_i = ic_done;
                saw_d = dc_done;
                break;
            end
        end
        mem_ack = 1'b0;
        ic_req  = 1'b0;
        dc_req  = 1'b0;
        cyc();
    endtask

    task automatic test_reset;
        logic si, sd;
        rst = 1'b1; ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b0;
        ic_addr = 16'h1000; dc_addr = 16'h2000; dc_wdata = 16'h0; mem_ack = 1'b0; mem_rdata = 16'h0;
        cyc();
        cyc();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %0b want 0", mem_req); end
        checks++; if (mem_we !== 1'b0 || mem_addr !== 16'h0) begin errors++; $display("FAIL rst_mem_we_addr: got %0b/%h want 0/0000", mem_we, mem_addr); end
        checks++; if (ic_rvalid !== 1'b0 || dc_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %0b/%0b want 0/0", ic_rvalid, dc_rvalid); end
        checks++; if (ic_done !== 1'b0 || dc_done !== 1'b0 || dc_wnext !== 1'b0) begin errors++; $display("FAIL rst_done_wnext: got %0b/%0b/%0b want 0/0/0", ic_done, dc_done, dc_wnext); end
        checks++; if (ic_rdata !== 16'h0 || dc_rdata !== 16'h0) begin errors++; $display("FAIL rst_rdata: got %h/%h want 0000/0000", ic_rdata, dc_rdata); end
        rst = 1'b0;
        cyc();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h2000) begin errors++; $display("FAIL rst_first_grant: got req %0b addr %h want 1 2000", mem_req, mem_addr); end
        finish_xfer(si, sd);
        checks++; if (sd !== 1'b1 || si !== 1'b0) begin errors++; $display("FAIL rst_first_done: got i %0b d %0b want i 0 d 1", si, sd); end
    endtask

    task automatic test_i_read;
        ic_req = 1'b1; ic_addr = 16'h1236; dc_req = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            mem_ack = 1'b1; mem_rdata = 16'h00A0 + 16'(i);
            #1;
            checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h1234 + 16'(i)) begin errors++; $display("FAIL iread_addr%0d: got req %0b we %0b addr %h want 1 0 %h", i, mem_req, mem_we, mem_addr, 16'h1234 + 16'(i)); end
            if (i == 0) begin
                checks++; if (ic_rvalid !== 1'b0) begin errors++; $display("FAIL iread_rvalid0: got %0b want 0", ic_rvalid); end
            end else begin
                checks++; if (ic_rvalid !== 1'b1 || ic_rdata !== 16'h00A0 + 16'(i - 1)) begin errors++; $display("FAIL iread_beat%0d: got v %0b d %h want 1 %h", i - 1, ic_rvalid, ic_rdata, 16'h00A0 + 16'(i - 1)); end
            end
            checks++; if (dc_rvalid !== 1'b0 || ic_done !== 1'b0) begin errors++; $display("FAIL iread_side%0d: got dc_rvalid %0b ic_done %0b want 0 0", i, dc_rvalid, ic_done); end
            cyc();
        end
        mem_ack = 1'b0; ic_req = 1'b0;
        #1;
        checks++; if (ic_rvalid !== 1'b1 || ic_rdata !== 16'h00A3) begin errors++; $display("FAIL iread_beat3: got v %0b d %h want 1 00a3", ic_rvalid, ic_rdata); end
        checks++; if (ic_done !== 1'b1 || dc_done !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL iread_done: got ic %0b dc %0b req %0b want 1 0 0", ic_done, dc_done, mem_req); end
        checks++; if (dc_rvalid !== 1'b0) begin errors++; $display("FAIL iread_dc_rvalid: got %0b want 0", dc_rvalid); end
        cyc();
        checks++; if (ic_done !== 1'b0 || ic_rvalid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL iread_idle: got done %0b rvalid %0b req %0b want 0 0 0", ic_done, ic_rvalid, mem_req); end
    endtask

    task automatic test_d_write;
        int k;
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 16'h0040; dc_wdata = 16'h5000;
        cyc();
        for (int j = 0; j < 8; j++) begin
            k = j / 2;
            dc_wdata = 16'h5000 + 16'(k);
            mem_ack = (j % 2 == 1);
            #1;
            checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0040 + 16'(k)) begin errors++; $display("FAIL dwr_addr%0d: got req %0b we %0b addr %h want 1 1 %h", j, mem_req, mem_we, mem_addr, 16'h0040 + 16'(k)); end
            checks++; if (mem_wdata !== 16'h5000 + 16'(k)) begin errors++; $display("FAIL dwr_wdata%0d: got %h want %h", j, mem_wdata, 16'h5000 + 16'(k)); end
            checks++; if (dc_wnext !== mem_ack) begin errors++; $display("FAIL dwr_wnext%0d: got %0b want %0b", j, dc_wnext, mem_ack); end
            checks++; if (dc_done !== 1'b0 || dc_rvalid !== 1'b0) begin errors++; $display("FAIL dwr_side%0d: got done %0b rvalid %0b want 0 0", j, dc_done, dc_rvalid); end
            cyc();
        end
        mem_ack = 1'b1; dc_req = 1'b0;
        #1;
        checks++; if (dc_done !== 1'b1 || ic_done !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL dwr_done: got dc %0b ic %0b req %0b want 1 0 0", dc_done, ic_done, mem_req); end
        checks++; if (dc_wnext !== 1'b0 || dc_rvalid !== 1'b0) begin errors++; $display("FAIL dwr_done_side: got wnext %0b rvalid %0b want 0 0", dc_wnext, dc_rvalid); end
        mem_ack = 1'b0; dc_we = 1'b0;
        cyc();
        checks++; if (dc_done !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL dwr_idle: got done %0b req %0b want 0 0", dc_done, mem_req); end
    endtask

    task automatic test_back_to_back;
        logic        exp_d;
        logic [15:0] exp_addr;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        ic_req = 1'b1; ic_addr = 16'h1100; dc_req = 1'b1; dc_we = 1'b0; dc_addr = 16'h2200;
        cyc();
        for (int n = 0; n < 4; n++) begin
`ifdef ARB_RR_EN
            exp_d = (n % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            exp_addr = exp_d ? 16'h2200 : 16'h1100;
            checks++; if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin errors++; $display("FAIL b2b_grant%0d: got req %0b addr %h want 1 %h", n, mem_req, mem_addr, exp_addr); end
            mem_ack = 1'b1;
            for (int b = 0; b < 4; b++) begin
                mem_rdata = 16'h0B00 + 16'(n * 4 + b);
                cyc();
            end
            mem_ack = 1'b0;
            #1;
            checks++; if (dc_done !== exp_d || ic_done !== !exp_d) begin errors++; $display("FAIL b2b_done%0d: got ic %0b dc %0b want ic %0b dc %0b", n, ic_done, dc_done, !exp_d, exp_d); end
            checks++; if ((exp_d ? dc_rdata : ic_rdata) !== 16'h0B00 + 16'(n * 4 + 3)) begin errors++; $display("FAIL b2b_last_rdata%0d: got %h want %h", n, exp_d ? dc_rdata : ic_rdata, 16'h0B00 + 16'(n * 4 + 3)); end
            cyc();
            checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL b2b_idle%0d: got req %0b want 0", n, mem_req); end
            if (n == 3) begin
                ic_req = 1'b0; dc_req = 1'b0;
            end
            cyc();
        end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL b2b_end: got req %0b want 0", mem_req); end
    endtask

    task automatic test_mid_reset;
        logic si, sd;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 16'h3000;
        cyc();
        mem_ack = 1'b1; mem_rdata = 16'h00D0;
        cyc();
        mem_rdata = 16'h00D1;
        cyc();
        checks++; if (mem_addr !== 16'h3002) begin errors++; $display("FAIL mrst_pre_addr: got %h want 3002", mem_addr); end
        rst = 1'b1; mem_ack = 1'b0;
        cyc();
        checks++; if (mem_req !== 1'b0 || mem_addr !== 16'h0 || dc_done !== 1'b0 || dc_rvalid !== 1'b0) begin errors++; $display("FAIL mrst_abort: got req %0b addr %h done %0b rvalid %0b want 0 0000 0 0", mem_req, mem_addr, dc_done, dc_rvalid); end
        rst = 1'b0; dc_req = 1'b0;
        cyc();
        checks++; if (dc_done !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL mrst_no_done: got done %0b req %0b want 0 0", dc_done, mem_req); end
        dc_req = 1'b1;
        cyc();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h3000) begin errors++; $display("FAIL mrst_restart: got req %0b addr %h want 1 3000", mem_req, mem_addr); end
        finish_xfer(si, sd);
        checks++; if (sd !== 1'b1 || si !== 1'b0) begin errors++; $display("FAIL mrst_done: got i %0b d %0b want i 0 d 1", si, sd); end
    endtask

    task automatic test_stray_ack;
        logic si, sd;
        ic_req = 1'b0; dc_req = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++; if (ic_rvalid !== 1'b0 || dc_rvalid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL stray_ack%0d: got iv %0b dv %0b req %0b want 0 0 0", i, ic_rvalid, dc_rvalid, mem_req); end
            checks++; if (ic_done !== 1'b0 || dc_done !== 1'b0) begin errors++; $display("FAIL stray_done%0d: got ic %0b dc %0b want 0 0", i, ic_done, dc_done); end
        end
        mem_ack = 1'b0;
        ic_req = 1'b1; ic_addr = 16'h0008;
        cyc();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0008) begin errors++; $display("FAIL stray_next: got req %0b addr %h want 1 0008", mem_req, mem_addr); end
        finish_xfer(si, sd);
        checks++; if (si !== 1'b1 || sd !== 1'b0) begin errors++; $display("FAIL stray_next_done: got i %0b d %0b want i 1 d 0", si, sd); end
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_back_to_back();
        test_mid_reset();
        test_stray_ack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
